// File: rtl/cvxif_tracker_pkg.sv
// Shared types and sizes for the CV-X-IF coprocessor issue tracker.
package cvxif_tracker_pkg;

   localparam int unsigned X_NUM_RS       = 2;
   localparam int unsigned X_ID_WIDTH     = 4;
   localparam int unsigned X_RFR_WIDTH    = 32;
   localparam int unsigned X_HARTID_WIDTH = 1;
   localparam int unsigned DEFAULT_DEPTH  = 4;
   localparam int unsigned INSTR_WIDTH    = 32;
   // Widest pointer needed for DEPTH = 16 (4 index bits plus wrap bit)
   localparam int unsigned PTR_MAX_W      = 5;

   typedef logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs_vec_t;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0]    instr;
      logic [X_HARTID_WIDTH-1:0] hartid;
      logic [X_ID_WIDTH-1:0]     id;
   } x_issue_req_t;

   typedef struct packed {
      logic                accept;
      logic                writeback;
      logic [X_NUM_RS-1:0] register_read;
      logic                loadstore;
   } x_issue_resp_t;

   typedef struct packed {
      logic [X_HARTID_WIDTH-1:0] hartid;
      logic [X_ID_WIDTH-1:0]     id;
      rs_vec_t                   rs;
   } x_register_t;

   typedef struct packed {
      logic [X_HARTID_WIDTH-1:0] hartid;
      logic [X_ID_WIDTH-1:0]     id;
      logic                      commit_kill;
   } x_commit_t;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0]    instr;
      logic [X_ID_WIDTH-1:0]     id;
      logic [X_HARTID_WIDTH-1:0] hartid;
      rs_vec_t                   rs;
      logic                      accepted;
      logic                      reg_done;
      logic                      committed;
      logic                      kill;
   } entry_t;

   // Pointers carry one wrap bit above aw index bits.
   function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] a,
                                      input logic [PTR_MAX_W-1:0] b);
      return a == b;
   endfunction

   function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wr,
                                     input logic [PTR_MAX_W-1:0] rd,
                                     input int unsigned aw);
      logic [PTR_MAX_W-1:0] low_mask;
      logic [PTR_MAX_W-1:0] diff;
      low_mask = PTR_MAX_W'((1 << aw) - 1);
      diff     = wr ^ rd;
      return (|((diff >> aw) & PTR_MAX_W'(1))) && ((diff & low_mask) == '0);
   endfunction

endpackage

// File: rtl/core_v_xif.sv
// Coprocessor-facing subset of the CV-X-IF: issue, register and commit channels.
interface core_v_xif;
   import cvxif_tracker_pkg::*;

   logic          issue_valid;
   logic          issue_ready;
   x_issue_req_t  issue_req;
   x_issue_resp_t issue_resp;

   logic          register_valid;
   logic          register_ready;
   x_register_t   register;

   logic          commit_valid;
   x_commit_t     commit;

   modport core_v_xif_coprocessor_issue (
      input  issue_valid, issue_req,
      output issue_ready, issue_resp
   );

   modport core_v_xif_coprocessor_register (
      input  register_valid, register,
      output register_ready
   );

   modport core_v_xif_coprocessor_commit (
      input  commit_valid, commit
   );

endinterface

// File: rtl/cvxif_issue_tracker.sv
// In-order tracker joining issue, register and commit per instruction and
// handing accepted, committed, non-killed entries to the execute unit.
module cvxif_issue_tracker
   import cvxif_tracker_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   core_v_xif.core_v_xif_coprocessor_issue    xif_issue,
   core_v_xif.core_v_xif_coprocessor_register xif_register,
   core_v_xif.core_v_xif_coprocessor_commit   xif_commit,
   input  logic                              dec_accept_i,
   input  logic                              dec_writeback_i,
   input  logic [X_NUM_RS-1:0]               dec_rs_read_i,
   output logic                              exec_valid_o,
   input  logic                              exec_ready_i,
   output logic [INSTR_WIDTH-1:0]            exec_instr_o,
   output logic [X_ID_WIDTH-1:0]             exec_id_o,
   output logic [X_HARTID_WIDTH-1:0]         exec_hartid_o,
   output logic [X_NUM_RS*X_RFR_WIDTH-1:0]   exec_rs_o,
   output logic [$clog2(DEPTH):0]            occupancy_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr, reg_ptr, cmt_ptr, rd_ptr;
   entry_t        entries [DEPTH];
   entry_t        head;

   logic issue_hs, reg_hs, cmt_pending, cmt_ok;
   logic head_live, head_done, head_dispatch, pop;

   assign xif_issue.issue_ready      = !ptr_full(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr), AW);
   assign xif_register.register_ready = !ptr_empty(PTR_MAX_W'(reg_ptr), PTR_MAX_W'(wr_ptr));

   // Decoder verdict is passed straight through in the issue cycle
   always_comb begin
      xif_issue.issue_resp               = '0;
      xif_issue.issue_resp.accept        = dec_accept_i;
      xif_issue.issue_resp.writeback     = dec_writeback_i;
      xif_issue.issue_resp.register_read = dec_rs_read_i;
      xif_issue.issue_resp.loadstore     = 1'b0;
   end

   assign issue_hs    = xif_issue.issue_valid && xif_issue.issue_ready;
   assign reg_hs      = xif_register.register_valid && xif_register.register_ready;
   assign cmt_pending = !ptr_empty(PTR_MAX_W'(cmt_ptr), PTR_MAX_W'(wr_ptr));
   // An empty commit window is bridged by the entry being allocated this cycle
   assign cmt_ok      = xif_commit.commit_valid && (cmt_pending || issue_hs);

   assign head          = entries[rd_ptr[AW-1:0]];
   assign head_live     = !ptr_empty(PTR_MAX_W'(rd_ptr), PTR_MAX_W'(wr_ptr));
   assign head_done     = head_live && head.reg_done && head.committed;
   assign head_dispatch = head.accepted && !head.kill;
   assign pop           = head_done && (!head_dispatch || exec_ready_i);

   assign exec_valid_o  = head_done && head_dispatch;
   assign exec_instr_o  = head.instr;
   assign exec_id_o     = head.id;
   assign exec_hartid_o = head.hartid;
   assign exec_rs_o     = head.rs;
   assign occupancy_o   = wr_ptr - rd_ptr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         reg_ptr <= '0;
         cmt_ptr <= '0;
         rd_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         if (issue_hs) begin
            entries[wr_ptr[AW-1:0]].instr     <= xif_issue.issue_req.instr;
            entries[wr_ptr[AW-1:0]].id        <= xif_issue.issue_req.id;
            entries[wr_ptr[AW-1:0]].hartid    <= xif_issue.issue_req.hartid;
            entries[wr_ptr[AW-1:0]].rs        <= '0;
            entries[wr_ptr[AW-1:0]].accepted  <= dec_accept_i;
            entries[wr_ptr[AW-1:0]].reg_done  <= 1'b0;
            entries[wr_ptr[AW-1:0]].committed <= 1'b0;
            entries[wr_ptr[AW-1:0]].kill      <= 1'b0;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (reg_hs) begin
            entries[reg_ptr[AW-1:0]].rs       <= xif_register.register.rs;
            entries[reg_ptr[AW-1:0]].reg_done <= 1'b1;
            reg_ptr <= reg_ptr + PW'(1);
         end
         // Placed after allocation so a bypassed commit overrides the fresh flags
         if (cmt_ok) begin
            entries[cmt_ptr[AW-1:0]].committed <= 1'b1;
            entries[cmt_ptr[AW-1:0]].kill      <= xif_commit.commit.commit_kill;
            cmt_ptr <= cmt_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   a_commit_orphan: assert property (@(posedge clk_i) disable iff (!rst_ni)
      xif_commit.commit_valid |-> (cmt_pending || issue_hs));

   a_commit_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (xif_commit.commit_valid && cmt_pending) |->
         (xif_commit.commit.id == entries[cmt_ptr[AW-1:0]].id &&
          xif_commit.commit.hartid == entries[cmt_ptr[AW-1:0]].hartid));

   a_commit_bypass_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (xif_commit.commit_valid && !cmt_pending && issue_hs) |->
         (xif_commit.commit.id == xif_issue.issue_req.id));

   a_register_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
      reg_hs |-> (xif_register.register.id == entries[reg_ptr[AW-1:0]].id &&
                  xif_register.register.hartid == entries[reg_ptr[AW-1:0]].hartid));

endmodule

// File: tb/tb_cvxif_issue_tracker.sv
// Directed self-checking bench for cvxif_issue_tracker (DEPTH = 4).
module tb_cvxif_issue_tracker;
   import cvxif_tracker_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        dec_accept;
   logic        dec_writeback;
   logic [1:0]  dec_rs_read;
   logic        exec_valid;
   logic        exec_ready;
   logic [31:0] exec_instr;
   logic [3:0]  exec_id;
   logic [0:0]  exec_hartid;
   logic [63:0] exec_rs;
   logic [2:0]  occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   core_v_xif xif ();

   cvxif_issue_tracker #(.DEPTH(4)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .xif_issue       (xif),
      .xif_register    (xif),
      .xif_commit      (xif),
      .dec_accept_i    (dec_accept),
      .dec_writeback_i (dec_writeback),
      .dec_rs_read_i   (dec_rs_read),
      .exec_valid_o    (exec_valid),
      .exec_ready_i    (exec_ready),
      .exec_instr_o    (exec_instr),
      .exec_id_o       (exec_id),
      .exec_hartid_o   (exec_hartid),
      .exec_rs_o       (exec_rs),
      .occupancy_o     (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the drive point just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input logic v, input logic [3:0] id, input logic acc);
      xif.issue_valid = v;
      xif.issue_req   = '{instr: {28'hA5A5_000, id}, hartid: 1'b0, id: id};
      dec_accept      = acc;
   endtask

   task automatic set_reg(input logic v, input logic [3:0] id,
                          input logic [31:0] rs0, input logic [31:0] rs1);
      xif.register_valid       = v;
      xif.register.hartid      = 1'b0;
      xif.register.id          = id;
      xif.register.rs[0]       = rs0;
      xif.register.rs[1]       = rs1;
   endtask

   task automatic set_cmt(input logic v, input logic [3:0] id, input logic kill);
      xif.commit_valid = v;
      xif.commit       = '{hartid: 1'b0, id: id, commit_kill: kill};
   endtask

   task automatic idle();
      set_issue(1'b0, 4'd0, 1'b0);
      set_reg(1'b0, 4'd0, 32'h0, 32'h0);
      set_cmt(1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      exec_ready = 1'b0;
      dec_writeback = 1'b0;
      dec_rs_read = 2'b00;
      idle();
      repeat (2) @(posedge clk);
      #3;
      n_cmp++; if (xif.issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_issue_ready got %0b want 1", xif.issue_ready); end
      n_cmp++; if (xif.register_ready !== 1'b0) begin n_bad++; $display("FAIL rst_register_ready got %0b want 0", xif.register_ready); end
      n_cmp++; if (exec_valid !== 1'b0) begin n_bad++; $display("FAIL rst_exec_valid got %0b want 0", exec_valid); end
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_dispatch();
      cyc();
      set_issue(1'b1, 4'd3, 1'b1);
      dec_writeback = 1'b1;
      dec_rs_read = 2'b11;
      #2;
      n_cmp++; if (xif.issue_resp !== 5'b1_1_11_0) begin n_bad++; $display("FAIL disp_issue_resp got %b want 11110", xif.issue_resp); end
      n_cmp++; if (xif.register_ready !== 1'b0) begin n_bad++; $display("FAIL disp_reg_ready_c0 got %0b want 0", xif.register_ready); end
      cyc();
      idle();
      set_reg(1'b1, 4'd3, 32'h11, 32'h22);
      #2;
      n_cmp++; if (xif.register_ready !== 1'b1) begin n_bad++; $display("FAIL disp_reg_ready_c1 got %0b want 1", xif.register_ready); end
      n_cmp++; if (occupancy !== 3'd1) begin n_bad++; $display("FAIL disp_occ_c1 got %0d want 1", occupancy); end
      cyc();
      idle();
      set_cmt(1'b1, 4'd3, 1'b0);
      #2;
      n_cmp++; if (exec_valid !== 1'b0) begin n_bad++; $display("FAIL disp_valid_c2 got %0b want 0", exec_valid); end
      cyc();
      idle();
      #2;
      n_cmp++; if (exec_valid !== 1'b1) begin n_bad++; $display("FAIL disp_valid_c3 got %0b want 1", exec_valid); end
      n_cmp++; if (exec_id !== 4'd3) begin n_bad++; $display("FAIL disp_id got %0d want 3", exec_id); end
      n_cmp++; if (exec_rs !== 64'h00000022_00000011) begin n_bad++; $display("FAIL disp_rs got %h want 0000002200000011", exec_rs); end
      n_cmp++; if (exec_instr !== 32'hA5A5_0003) begin n_bad++; $display("FAIL disp_instr got %h want a5a50003", exec_instr); end
      cyc();
      #2;
      n_cmp++; if (exec_valid !== 1'b1 || exec_id !== 4'd3) begin n_bad++; $display("FAIL disp_hold got v=%0b id=%0d want v=1 id=3", exec_valid, exec_id); end
      exec_ready = 1'b1;
      cyc();
      exec_ready = 1'b0;
      #2;
      n_cmp++; if (exec_valid !== 1'b0) begin n_bad++; $display("FAIL disp_valid_after got %0b want 0", exec_valid); end
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL disp_occ_after got %0d want 0", occupancy); end
   endtask

   task automatic test_reject();
      logic seen_valid;
      seen_valid = 1'b0;
      cyc();
      set_issue(1'b1, 4'd1, 1'b0);
      #2;
      n_cmp++; if (xif.issue_resp.accept !== 1'b0) begin n_bad++; $display("FAIL rej_accept got %0b want 0", xif.issue_resp.accept); end
      cyc();
      idle();
      set_reg(1'b1, 4'd1, 32'hAA, 32'hBB);
      #2; seen_valid |= exec_valid;
      cyc();
      idle();
      set_cmt(1'b1, 4'd1, 1'b0);
      #2; seen_valid |= exec_valid;
      cyc();
      idle();
      #2; seen_valid |= exec_valid;
      n_cmp++; if (occupancy !== 3'd1) begin n_bad++; $display("FAIL rej_occ_retire got %0d want 1", occupancy); end
      cyc();
      #2; seen_valid |= exec_valid;
      n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL rej_valid_seen got %0b want 0", seen_valid); end
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL rej_occ_end got %0d want 0", occupancy); end
   endtask

   task automatic test_kill();
      cyc();
      set_issue(1'b1, 4'd0, 1'b1);
      cyc();
      idle();
      set_issue(1'b1, 4'd1, 1'b1);
      set_cmt(1'b1, 4'd0, 1'b0);
      cyc();
      idle();
      set_cmt(1'b1, 4'd1, 1'b1);
      set_reg(1'b1, 4'd0, 32'h44, 32'h33);
      cyc();
      idle();
      set_reg(1'b1, 4'd1, 32'h55, 32'h66);
      #2;
      n_cmp++; if (exec_valid !== 1'b1 || exec_id !== 4'd0) begin n_bad++; $display("FAIL kill_first got v=%0b id=%0d want v=1 id=0", exec_valid, exec_id); end
      n_cmp++; if (exec_rs !== 64'h00000033_00000044) begin n_bad++; $display("FAIL kill_rs got %h want 0000003300000044", exec_rs); end
      exec_ready = 1'b1;
      cyc();
      idle();
      exec_ready = 1'b0;
      #2;
      n_cmp++; if (exec_valid !== 1'b0) begin n_bad++; $display("FAIL kill_drop_valid got %0b want 0", exec_valid); end
      n_cmp++; if (occupancy !== 3'd1) begin n_bad++; $display("FAIL kill_occ_mid got %0d want 1", occupancy); end
      cyc();
      #2;
      n_cmp++; if (exec_valid !== 1'b0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL kill_end got v=%0b occ=%0d want v=0 occ=0", exec_valid, occupancy); end
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         cyc();
         set_issue(1'b1, 4'(8 + k), 1'b1);
         #2;
         n_cmp++; if (xif.issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_%0d got %0b want 1", k, xif.issue_ready); end
      end
      cyc();
      set_issue(1'b1, 4'd12, 1'b1);
      #2;
      n_cmp++; if (xif.issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_5th got %0b want 0", xif.issue_ready); end
      n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL full_occ got %0d want 4", occupancy); end
      for (int k = 0; k < 4; k++) begin
         cyc();
         idle();
         set_reg(1'b1, 4'(8 + k), 32'(k), 32'(k + 16));
         set_cmt(1'b1, 4'(8 + k), 1'b0);
      end
      cyc();
      idle();
      #2;
      n_cmp++; if (exec_valid !== 1'b1 || exec_id !== 4'd8) begin n_bad++; $display("FAIL full_head got v=%0b id=%0d want v=1 id=8", exec_valid, exec_id); end
      n_cmp++; if (xif.issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_hold got %0b want 0", xif.issue_ready); end
      exec_ready = 1'b1;
      cyc();
      exec_ready = 1'b0;
      #2;
      n_cmp++; if (xif.issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_pop got %0b want 1", xif.issue_ready); end
      n_cmp++; if (occupancy !== 3'd3 || exec_id !== 4'd9) begin n_bad++; $display("FAIL full_after_pop got occ=%0d id=%0d want occ=3 id=9", occupancy, exec_id); end
      exec_ready = 1'b1;
      repeat (3) cyc();
      exec_ready = 1'b0;
      #2;
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL full_drain got %0d want 0", occupancy); end
   endtask

   task automatic test_bypass();
      cyc();
      set_issue(1'b1, 4'd5, 1'b1);
      set_cmt(1'b1, 4'd5, 1'b0);
      cyc();
      idle();
      set_reg(1'b1, 4'd5, 32'h77, 32'h88);
      #2;
      n_cmp++; if (exec_valid !== 1'b0 || occupancy !== 3'd1) begin n_bad++; $display("FAIL byp_pre got v=%0b occ=%0d want v=0 occ=1", exec_valid, occupancy); end
      cyc();
      idle();
      #2;
      n_cmp++; if (exec_valid !== 1'b1 || exec_id !== 4'd5) begin n_bad++; $display("FAIL byp_dispatch got v=%0b id=%0d want v=1 id=5", exec_valid, exec_id); end
      exec_ready = 1'b1;
      cyc();
      exec_ready = 1'b0;
      #2;
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL byp_occ got %0d want 0", occupancy); end
   endtask

   task automatic test_async_reset();
      cyc();
      set_issue(1'b1, 4'd2, 1'b1);
      cyc();
      set_issue(1'b1, 4'd3, 1'b1);
      set_reg(1'b1, 4'd2, 32'h1, 32'h2);
      set_cmt(1'b1, 4'd2, 1'b0);
      cyc();
      idle();
      set_issue(1'b1, 4'd4, 1'b1);
      cyc();
      idle();
      #2;
      n_cmp++; if (exec_valid !== 1'b1 || occupancy !== 3'd3) begin n_bad++; $display("FAIL ar_pre got v=%0b occ=%0d want v=1 occ=3", exec_valid, occupancy); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (exec_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got %0b want 0", exec_valid); end
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL ar_occ got %0d want 0", occupancy); end
      n_cmp++; if (xif.register_ready !== 1'b0) begin n_bad++; $display("FAIL ar_reg_ready got %0b want 0", xif.register_ready); end
      n_cmp++; if (xif.issue_ready !== 1'b1) begin n_bad++; $display("FAIL ar_issue_ready got %0b want 1", xif.issue_ready); end
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_dispatch();
      test_reject();
      test_kill();
      test_full();
      test_bypass();
      test_async_reset();
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
